// File: rtl/rs_syndrome_engine_pkg.sv
// Shared types and defaults for the Reed-Solomon syndrome engine.
package rs_pkg;

    localparam int SYM_W_DEF    = 8;
    localparam int MAX_NSYM_DEF = 32;
    localparam int NSYM_W       = 6;
    localparam int LEN_W        = 9;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ACCEPT,
        MAC,
        DONE
    } state_t;

endpackage

// File: rtl/rs_syndrome_engine_gf_mul.sv
// GF(2^SYM_W) multiplier, shift-and-add reduced modulo {1, poly}; purely combinational.
module gf_mul #(
    parameter int SYM_W = 8
) (
    input  logic [SYM_W-1:0] a,
    input  logic [SYM_W-1:0] b,
    input  logic [SYM_W-1:0] poly,
    output logic [SYM_W-1:0] p
);

    logic [SYM_W-1:0] acc;

    // NOTE: blocking assignments here on purpose; acc is a combinational chain rebuilt each evaluation.
    always_comb begin
        acc = '0;
        for (int i = SYM_W - 1; i >= 0; i--) begin
            acc = {acc[SYM_W-2:0], 1'b0} ^ (acc[SYM_W-1] ? poly : '0);
            if (b[i]) acc = acc ^ a;
        end
        p = acc;
    end

endmodule

// File: rtl/rs_syndrome_engine.sv
// Streaming Reed-Solomon syndrome engine: Horner update S[i] = S[i]*root[i] ^ r,
// LANES syndromes per cycle, runtime-programmable field, roots and block length.
module rs_syndrome_engine
    import rs_pkg::*;
#(
    parameter int SYM_W    = SYM_W_DEF,
    parameter int MAX_NSYM = MAX_NSYM_DEF,
    parameter int LANES    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SYM_W-1:0]  cfg_poly,
    input  logic [SYM_W-1:0]  cfg_alpha,
    input  logic [SYM_W-1:0]  cfg_root0,
    input  logic [5:0]        cfg_nsym,
    input  logic [7:0]        cfg_len,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SYM_W-1:0]  in_data,
    input  logic              in_last,
    input  logic [4:0]        syn_addr,
    output logic [SYM_W-1:0]  syn_data,
    output logic              busy,
    output logic              done,
    output logic              nonzero,
    output logic              len_err
);

    localparam int IDX_W = $clog2(MAX_NSYM);
    localparam int NGRP  = (MAX_NSYM + LANES - 1) / LANES;
    localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;

    state_t              state;
    logic [SYM_W-1:0]    poly_q, alpha_q, root0_q, sym_q;
    logic [NSYM_W-1:0]   nsym_q, init_idx, nsym_clamped;
    logic [LEN_W-1:0]    remaining, len_ext;
    logic [GRP_W-1:0]    grp, last_grp;
    logic [SYM_W-1:0]    syn  [MAX_NSYM];
    logic [SYM_W-1:0]    root [MAX_NSYM];
    logic [SYM_W-1:0]    syn_or;

    logic [SYM_W-1:0]    lane_a [LANES];
    logic [SYM_W-1:0]    lane_b [LANES];
    logic [SYM_W-1:0]    lane_p [LANES];
    logic [IDX_W-1:0]    lane_idx [LANES];
    logic                lane_en [LANES];

    assign nsym_clamped = (int'(cfg_nsym) > MAX_NSYM) ? NSYM_W'(MAX_NSYM) : cfg_nsym;
    assign len_ext      = (cfg_len == 8'd0) ? LEN_W'(256) : {1'b0, cfg_len};
    assign last_grp     = (nsym_q == '0) ? '0 : GRP_W'((int'(nsym_q) - 1) / LANES);

    // Lane 0 doubles as the root generator while in INIT.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_idx[k] = IDX_W'(int'(grp) * LANES + k);
            lane_en[k]  = (int'(grp) * LANES + k) < int'(nsym_q);
            lane_a[k]   = syn[lane_idx[k]];
            lane_b[k]   = root[lane_idx[k]];
        end
        if (state == INIT) begin
            lane_a[0] = root[IDX_W'(int'(init_idx) - 1)];
            lane_b[0] = alpha_q;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        gf_mul #(.SYM_W(SYM_W)) u_mul (
            .a    (lane_a[k]),
            .b    (lane_b[k]),
            .poly (poly_q),
            .p    (lane_p[k])
        );
    end

    always_comb begin
        syn_or = '0;
        for (int i = 0; i < MAX_NSYM; i++) syn_or = syn_or | syn[i];
    end

    assign syn_data = (NSYM_W'(syn_addr) < nsym_q) ? syn[IDX_W'(syn_addr)] : '0;

    // NOTE: the syndrome/root banks are plain flops, so they take the async reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            poly_q    <= '0;
            alpha_q   <= '0;
            root0_q   <= '0;
            sym_q     <= '0;
            nsym_q    <= '0;
            init_idx  <= '0;
            remaining <= '0;
            grp       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            nonzero   <= 1'b0;
            len_err   <= 1'b0;
            for (int i = 0; i < MAX_NSYM; i++) begin
                syn[i]  <= '0;
                root[i] <= '0;
            end
        end else if (start) begin
            poly_q    <= cfg_poly;
            alpha_q   <= cfg_alpha;
            root0_q   <= cfg_root0;
            nsym_q    <= nsym_clamped;
            remaining <= len_ext;
            init_idx  <= '0;
            grp       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            nonzero   <= 1'b0;
            len_err   <= 1'b0;
            state     <= INIT;
            for (int i = 0; i < MAX_NSYM; i++) syn[i] <= '0;
        end else begin
            case (state)
                IDLE: done <= 1'b0;
                INIT: begin
                    if (init_idx < nsym_q)
                        root[IDX_W'(init_idx)] <= (init_idx == '0) ? root0_q : lane_p[0];
                    if ((init_idx + NSYM_W'(1)) >= nsym_q) begin
                        in_ready <= 1'b1;
                        state    <= ACCEPT;
                    end else begin
                        init_idx <= init_idx + NSYM_W'(1);
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        sym_q     <= in_data;
                        grp       <= '0;
                        remaining <= remaining - LEN_W'(1);
                        if (in_last != (remaining == LEN_W'(1))) len_err <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= MAC;
                    end
                end
                MAC: begin
                    for (int k = 0; k < LANES; k++)
                        if (lane_en[k]) syn[lane_idx[k]] <= lane_p[k] ^ sym_q;
                    if (grp == last_grp) begin
                        if (remaining != '0) begin
                            in_ready <= 1'b1;
                            state    <= ACCEPT;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        grp <= grp + GRP_W'(1);
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    nonzero <= |syn_or;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_syndrome_engine.sv
// Directed bench for rs_syndrome_engine: GF(2^8), poly 0x1D, alpha 0x02 unless a test says otherwise.
module tb_rs_syndrome_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cfg_poly, cfg_alpha, cfg_root0;
    logic [5:0] cfg_nsym;
    logic [7:0] cfg_len;
    logic       start, in_valid, in_last;
    logic       in_ready;
    logic [7:0] in_data;
    logic [4:0] syn_addr;
    logic [7:0] syn_data;
    logic       busy, done, nonzero, len_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] blk   [10];
    logic [7:0] exp_s [8];

    rs_syndrome_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_poly  (cfg_poly),
        .cfg_alpha (cfg_alpha),
        .cfg_root0 (cfg_root0),
        .cfg_nsym  (cfg_nsym),
        .cfg_len   (cfg_len),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .syn_addr  (syn_addr),
        .syn_data  (syn_data),
        .busy      (busy),
        .done      (done),
        .nonzero   (nonzero),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_blk();
        for (int i = 0; i < 10; i++) blk[i] = 8'h00;
    endtask

    task automatic start_blk(input logic [7:0] root0, input logic [5:0] nsym, input logic [7:0] len);
        @(negedge clk);
        cfg_poly  = 8'h1D;
        cfg_alpha = 8'h02;
        cfg_root0 = root0;
        cfg_nsym  = nsym;
        cfg_len   = len;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        cfg_root0 = 8'hEE;
        cfg_nsym  = 6'd1;
        cfg_len   = 8'd3;
    endtask

    task automatic send_sym(input logic [7:0] d, input logic last);
        int n;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("handshake_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_block(input int len, input int last_pos);
        for (int i = 0; i < len; i++) send_sym(blk[i], (i + 1) == last_pos);
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        check(tag, n, exp_lat);
    endtask

    task automatic check_syn(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            syn_addr = 5'(i);
            #1;
            check(tag, syn_data, exp_s[i]);
        end
    endtask

    initial begin
        int n_acc, prev;
        bit saw_done;

        rst_n = 1'b0;
        cfg_poly = 8'h1D; cfg_alpha = 8'h02; cfg_root0 = 8'h01;
        cfg_nsym = 6'd4;  cfg_len = 8'd10;
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; syn_addr = 5'd0;
        #23 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_nonzero", nonzero, 0);
        check("rst_len_err", len_err, 0);
        check("rst_syn", syn_data, 0);

        // All-zero block
        clear_blk();
        start_blk(8'h01, 6'd4, 8'd10);
        check("busy_after_start", busy, 1);
        send_block(10, 10);
        wait_done("zero_latency", 2);
        check("zero_busy", busy, 0);
        check("zero_nonzero", nonzero, 0);
        exp_s = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_syn("zero_syn", 4);

        // Degree-0 coefficient only
        blk[9] = 8'h01;
        start_blk(8'h01, 6'd4, 8'd10);
        send_block(10, 10);
        wait_done("deg0_latency", 2);
        check("deg0_nonzero", nonzero, 1);
        exp_s = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        check_syn("deg0_syn", 4);

        // Degree-1 coefficient only, root0 = 1 then 2
        clear_blk();
        blk[8] = 8'h01;
        start_blk(8'h01, 6'd4, 8'd10);
        send_block(10, 10);
        wait_done("deg1_latency", 2);
        exp_s = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
        check_syn("deg1_syn", 4);
        start_blk(8'h02, 6'd4, 8'd10);
        send_block(10, 10);
        wait_done("deg1r2_latency", 2);
        exp_s = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
        check_syn("deg1r2_syn", 4);

        // Root generation crossing the field reduction
        start_blk(8'h80, 6'd4, 8'd10);
        send_block(10, 10);
        wait_done("reduce_latency", 2);
        exp_s = '{8'h80, 8'h1D, 8'h3A, 8'h74, 8'h00, 8'h00, 8'h00, 8'h00};
        check_syn("reduce_syn", 4);

        // x^2 + 5: S_i = root_i^2 ^ 5
        clear_blk();
        blk[7] = 8'h01;
        blk[9] = 8'h05;
        start_blk(8'h01, 6'd4, 8'd10);
        send_block(10, 10);
        wait_done("mix_latency", 2);
        exp_s = '{8'h04, 8'h01, 8'h15, 8'h45, 8'h00, 8'h00, 8'h00, 8'h00};
        check_syn("mix_syn", 4);
        syn_addr = 5'd4;
        #1;
        check("mix_addr_oob", syn_data, 0);

        // Throughput with in_valid held: nsym 8, len 8, degree-1 coefficient 0x01
        start_blk(8'h01, 6'd8, 8'd8);
        in_valid = 1'b1;
        n_acc = 0;
        prev = -1;
        for (int c = 0; c < 60; c++) begin
            in_data = (n_acc == 6) ? 8'h01 : 8'h00;
            in_last = (n_acc == 7);
            if (in_ready) begin
                if (prev >= 0) check("tput_gap", c - prev, 3);
                prev = c;
                n_acc++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("tput_count", n_acc, 8);
        check("tput_busy", busy, 0);
        check("tput_len_err", len_err, 0);
        exp_s = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        check_syn("tput_syn", 8);

        // in_last on the 5th of 10 symbols
        clear_blk();
        start_blk(8'h01, 6'd4, 8'd10);
        send_block(10, 5);
        wait_done("lenerr_latency", 2);
        check("lenerr_set", len_err, 1);
        start_blk(8'h01, 6'd4, 8'd10);
        check("lenerr_cleared", len_err, 0);
        send_block(10, 10);
        wait_done("lenerr_clean_latency", 2);
        check("lenerr_clean", len_err, 0);

        // nsym clamped to 32: S[8] = a^8, S[31] = a^31
        blk[8] = 8'h01;
        start_blk(8'h01, 6'd40, 8'd10);
        send_block(10, 10);
        wait_done("clamp_latency", 9);
        syn_addr = 5'd8;
        #1;
        check("clamp_s8", syn_data, 8'h1D);
        syn_addr = 5'd31;
        #1;
        check("clamp_s31", syn_data, 8'hC0);

        // nsym 0: everything reads as zero
        blk[9] = 8'h07;
        start_blk(8'h01, 6'd0, 8'd10);
        send_block(10, 10);
        wait_done("nsym0_latency", 2);
        check("nsym0_nonzero", nonzero, 0);
        syn_addr = 5'd0;
        #1;
        check("nsym0_syn", syn_data, 0);

        // Async reset in the middle of MAC
        start_blk(8'h01, 6'd32, 8'd10);
        send_sym(8'h55, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_done", done, 0);
        check("arst_syn", syn_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("arst_no_done", saw_done, 0);

        // Restart mid-block: result must match a clean deg-1 run with root0 2
        for (int i = 0; i < 10; i++) blk[i] = 8'(8'h31 + 8'(i * 7));
        start_blk(8'h80, 6'd8, 8'd10);
        for (int i = 0; i < 4; i++) send_sym(blk[i], 1'b0);
        in_data  = 8'hFF;
        in_valid = 1'b1;
        start_blk(8'h02, 6'd4, 8'd10);
        in_valid = 1'b0;
        clear_blk();
        blk[8] = 8'h01;
        send_block(10, 10);
        wait_done("restart_latency", 2);
        check("restart_len_err", len_err, 0);
        exp_s = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
        check_syn("restart_syn", 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
